demux1_4_s2p: RTL and testbench
===============================

DEMUX1_4_S2P -- requirements
Module: demux1_4_s2p

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0, which sets bit placement: 0 puts the first serial bit in data_out[0]; 1 puts it in data_out[3].
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port clr_in, input, 1 bit: synchronous flush of the partial word.
REQ-005 The block SHALL have port data_in, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-007 The block SHALL have port ready_out, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port data_out, output, 4 bits: the assembled word.
REQ-009 The block SHALL have port valid_out, output, 1 bit: data_out holds an undelivered word.
REQ-010 The block SHALL have port ready_in, input, 1 bit: the downstream consumer takes data_out this cycle.
REQ-011 The block SHALL have port sel_out, output, 2 bits: the lane that the next data bit will write.
REQ-012 The block SHALL have port parity_err, output, 1 bit: parity failure flag for the word in data_out.

Function
REQ-013 A beat SHALL be accepted only on a cycle with valid_in=1 and ready_out=1.
- An accepted data beat writes data_in into the assembly lane selected by the internal 2-bit counter sel.
- With MSB_FIRST=1 the lane written is 3-sel.
REQ-014 sel SHALL increment by 1 on each accepted data beat and wrap from 3 to 0.
REQ-015 sel_out SHALL equal sel at all times.
REQ-016 The state machine SHALL have states COLLECT and PARITY.
- PARITY is present only when DEMUX_PARITY_EN is defined.
- Without the macro, acceptance at sel=3 completes the word and the machine stays in COLLECT.
REQ-017 On word completion, on the same clock edge:
- the 4-bit assembly (including the final bit) SHALL be loaded into data_out;
- valid_out SHALL be set;
- the assembly register SHALL be cleared.
- Latency: valid_out is high the cycle after the final beat is accepted.
REQ-018 valid_out SHALL stay high, and data_out SHALL stay stable, until a cycle with valid_out=1 and ready_in=1; on that cycle's edge valid_out clears unless a new word completes on the same edge.
REQ-019 ready_out SHALL be 0 only when the current beat would complete a word and valid_out=1 and ready_in=0; in every other case ready_out SHALL be 1.
- No word is ever overwritten or dropped.
REQ-020 When a word completes on the same edge as a downstream take, valid_out SHALL remain 1 and data_out SHALL take the new word (back-to-back throughput, one word per 4 beats).
REQ-021 clr_in=1 SHALL clear sel and the assembly register and return the state to COLLECT.
- clr_in leaves data_out, valid_out and parity_err unchanged.
- clr_in overrides a simultaneous valid_in beat; ready_out is 0 while clr_in=1.
REQ-022 Beats with valid_in=0 SHALL change no state.

Reset
REQ-023 While rst_n=0, irrespective of clk, the block SHALL hold:
- data_out=0, valid_out=0, parity_err=0;
- sel=0, sel_out=0;
- assembly register=0;
- state=COLLECT.
REQ-024 Reset asserted mid-word SHALL discard the partial word; after release, the first accepted beat goes to lane 0 (or lane 3 when MSB_FIRST=1).
REQ-025 ready_out SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-026 Defining macro DEMUX_PARITY_EN SHALL compile in a fifth, parity beat.
- After the data beat at sel=3 the machine enters PARITY.
- The next accepted beat is the even-parity bit; the word completes on that beat.
- parity_err loads with valid_out and equals (XOR of the 4 data bits) XOR the parity bit.
- The backpressure rule of REQ-019 applies to the parity beat, not to the sel=3 beat.
REQ-027 Without DEMUX_PARITY_EN, the PARITY state and checker SHALL be absent, parity_err SHALL be constant 0, and a word SHALL be 4 beats.

Verification
REQ-028 The bench SHALL cover these scenarios; stimulus -> required response:
- MSB_FIRST=0, beats 1,0,1,1, ready_in=1 -> data_out=4'b1101, valid_out high one cycle, sel_out sequence 0,1,2,3,0.
- MSB_FIRST=1, same beats -> data_out=4'b1011.
- ready_in=0, 8 continuous beats -> first word held, ready_out=0 on the 8th beat until ready_in=1, second word intact, no loss.
- 2 beats, then clr_in pulse, then beats 0,0,0,1 -> data_out=4'b1000.
- rst_n low after 3 beats, asynchronously between edges -> outputs 0 immediately, sel_out=0, next word assembles from lane 0.
- DEMUX_PARITY_EN: beats 1,1,0,0 then parity 1 -> data_out=4'b0011, parity_err=1; parity 0 -> parity_err=0.

Source files
------------

// File: rtl/demux1_4_s2p.sv
// demux1_4_s2p: 1-to-4 serial-to-parallel demux with valid/ready on both sides.
// Define DEMUX_PARITY_EN to add a fifth, even-parity beat per word.
module demux1_4_s2p #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_in,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [3:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic [1:0] sel_out,
  output logic       parity_err
);

`ifdef DEMUX_PARITY_EN
  typedef enum logic {COLLECT, PARITY} state_t;
`else
  typedef enum logic {COLLECT} state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] shreg_q, shreg_d;
  logic [3:0] dout_q, dout_d;
  logic       vout_q, vout_d;
  logic [1:0] lane;
  logic [3:0] merged;
  logic       last;
  logic       take;
  logic       beat;
`ifdef DEMUX_PARITY_EN
  logic       perr_q, perr_d;
`endif

  // State register: FSM state, lane counter, assembly and output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      sel_q   <= 2'd0;
      shreg_q <= 4'd0;
      dout_q  <= 4'd0;
      vout_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
`ifdef DEMUX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state, handshake and word assembly
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    vout_d  = vout_q;
`ifdef DEMUX_PARITY_EN
    perr_d  = perr_q;
    last    = (state_q == PARITY);
`else
    last    = (sel_q == 2'd3);
`endif
    lane = (MSB_FIRST != 0) ? (2'd3 - sel_q) : sel_q;
    merged = shreg_q;
    merged[lane] = data_in;
    // Stall only the completing beat, and only if the held word is stuck
    ready_out = !clr_in && !(last && vout_q && !ready_in);
    take = vout_q && ready_in;
    beat = valid_in && ready_out;
    if (take) vout_d = 1'b0;
    if (clr_in) begin
      sel_d   = 2'd0;
      shreg_d = 4'd0;
      state_d = COLLECT;
    end else if (beat) begin
`ifdef DEMUX_PARITY_EN
      unique case (state_q)
        COLLECT: begin
          shreg_d = merged;
          sel_d   = sel_q + 2'd1;
          if (sel_q == 2'd3) state_d = PARITY;
        end
        PARITY: begin
          dout_d  = shreg_q;
          vout_d  = 1'b1;
          perr_d  = ^shreg_q ^ data_in;
          shreg_d = 4'd0;
          state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
`else
      if (last) begin
        dout_d  = merged;
        vout_d  = 1'b1;
        shreg_d = 4'd0;
        sel_d   = 2'd0;
      end else begin
        shreg_d = merged;
        sel_d   = sel_q + 2'd1;
      end
`endif
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign sel_out   = sel_q;
`ifdef DEMUX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_4_s2p.sv
// tb_demux1_4_s2p: directed scoreboard bench for demux1_4_s2p.
// Two instances (LSB-first and MSB-first) share the same stimulus.
module tb_demux1_4_s2p;

`ifdef DEMUX_PARITY_EN
  localparam int WL = 5;
`else
  localparam int WL = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr_in;
  logic       data_in;
  logic       valid_in;
  logic       ready_in;
  logic       ready0, ready1;
  logic [3:0] data0, data1;
  logic       valid0, valid1;
  logic [1:0] sel0, sel1;
  logic       perr0, perr1;

  int total = 0;
  int bad = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  int         cnt = 0;
  logic [3:0] w0 = 4'd0;
  logic [3:0] w1 = 4'd0;

  demux1_4_s2p #(.MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_in(clr_in),
    .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready0), .data_out(data0),
    .valid_out(valid0), .ready_in(ready_in),
    .sel_out(sel0), .parity_err(perr0)
  );

  demux1_4_s2p #(.MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_in(clr_in),
    .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready1), .data_out(data1),
    .valid_out(valid1), .ready_in(ready_in),
    .sel_out(sel1), .parity_err(perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    cnt = 0;
    w0 = 4'd0;
    w1 = 4'd0;
  endtask

  task automatic model_accept(input logic b);
    logic p;
    if (cnt < 4) begin
      w0[cnt] = b;
      w1[3-cnt] = b;
    end
    cnt++;
    if (cnt == WL) begin
      p = (WL == 5) ? (^w0 ^ b) : 1'b0;
      q0.push_back({p, w0});
      q1.push_back({p, w1});
      model_clear();
    end
  endtask

  task automatic send(input logic b);
    int n;
    bit done;
    n = 0;
    done = 0;
    valid_in = 1'b1;
    data_in = b;
    while (!done) begin
      @(negedge clk);
      if (ready0) begin
        chk("sel_lsb", {6'd0, sel0}, (cnt < 4) ? cnt[7:0] : 8'd0);
        chk("sel_msb", {6'd0, sel1}, (cnt < 4) ? cnt[7:0] : 8'd0);
        @(posedge clk);
        #1;
        model_accept(b);
        done = 1;
      end else begin
        n++;
        if (n > 40) begin
          total++;
          bad++;
          $error("FAIL ready_timeout observed=0 expected=1");
          done = 1;
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] seq, input logic par);
    for (int i = 0; i < 4; i++) send(seq[i]);
`ifdef DEMUX_PARITY_EN
    send(par);
`else
    if (par) begin end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard whenever the consumer takes a word
  always @(negedge clk) begin
    if (rst_n && valid0 && ready_in) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_word_lsb observed=%0h expected=none", data0);
      end else begin
        chk("word_lsb", {3'd0, perr0, data0}, {3'd0, q0.pop_front()});
      end
    end
    if (rst_n && valid1 && ready_in) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_word_msb observed=%0h expected=none", data1);
      end else begin
        chk("word_msb", {3'd0, perr1, data1}, {3'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr_in = 1'b0;
    data_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    #2;
    chk("rst_data", {4'd0, data0}, 8'd0);
    chk("rst_valid", {7'd0, valid0}, 8'd0);
    chk("rst_sel", {6'd0, sel0}, 8'd0);
    chk("rst_perr", {7'd0, perr0}, 8'd0);
    chk("rst_data_msb", {4'd0, data1}, 8'd0);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {7'd0, ready0}, 8'd1);
    step();

    // Word 1,0,1,1 with idle gap mid-word
    send(1'b1);
    send(1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("idle_hold_sel", {6'd0, sel0}, 8'd2);
    step();
    send(1'b1);
    send(1'b1);
`ifdef DEMUX_PARITY_EN
    send(1'b1);
`endif
    @(negedge clk);
    chk("valid_pulse_hi", {7'd0, valid0}, 8'd1);
    chk("lsb_1101", {4'd0, data0}, 8'h0d);
    chk("msb_1011", {4'd0, data1}, 8'h0b);
    step();
    @(negedge clk);
    chk("valid_pulse_lo", {7'd0, valid0}, 8'd0);
    chk("sel_wrap", {6'd0, sel0}, 8'd0);
    step();

    // Backpressure: two words, consumer stalled
    ready_in = 1'b0;
    send_word(4'b1101, 1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
`ifdef DEMUX_PARITY_EN
    send(1'b0);
`endif
    valid_in = 1'b1;
    data_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready_lo", {7'd0, ready0}, 8'd0);
      chk("bp_valid_hold", {7'd0, valid0}, 8'd1);
      chk("bp_data_hold", {4'd0, data0}, {4'd0, q0[0][3:0]});
      step();
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("bp_ready_hi", {7'd0, ready0}, 8'd1);
    step();
    model_accept(1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {7'd0, valid0}, 8'd1);
    chk("b2b_lsb_0110", {4'd0, data0}, 8'h06);
    step();

    // Clear mid-word, overriding a beat
    send(1'b1);
    send(1'b1);
    clr_in = 1'b1;
    valid_in = 1'b1;
    data_in = 1'b1;
    @(negedge clk);
    chk("clr_ready_lo", {7'd0, ready0}, 8'd0);
    step();
    clr_in = 1'b0;
    valid_in = 1'b0;
    model_clear();
    @(negedge clk);
    chk("clr_sel", {6'd0, sel0}, 8'd0);
    step();
    send_word(4'b1000, 1'b1);
    @(negedge clk);
    chk("clr_lsb_1000", {4'd0, data0}, 8'h08);
    chk("clr_msb_0001", {4'd0, data1}, 8'h01);
    step();

    // Asynchronous reset mid-word
    send(1'b1);
    send(1'b0);
    send(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", {4'd0, data0}, 8'd0);
    chk("arst_sel", {6'd0, sel0}, 8'd0);
    chk("arst_valid", {7'd0, valid0}, 8'd0);
    chk("arst_sel_msb", {6'd0, sel1}, 8'd0);
    model_clear();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", {7'd0, ready0}, 8'd1);
    step();
    send_word(4'b0110, 1'b0);
    @(negedge clk);
    chk("arst_lsb_0110", {4'd0, data0}, 8'h06);
    step();

`ifdef DEMUX_PARITY_EN
    send_word(4'b0011, 1'b1);
    @(negedge clk);
    chk("par_data", {4'd0, data0}, 8'h03);
    chk("par_err_1", {7'd0, perr0}, 8'd1);
    step();
    send_word(4'b0011, 1'b0);
    @(negedge clk);
    chk("par_err_0", {7'd0, perr0}, 8'd0);
    step();
`endif

    repeat (3) step();
    chk("sb_empty_lsb", q0.size() > 255 ? 8'hff : q0.size(), 8'd0);
    chk("sb_empty_msb", q1.size() > 255 ? 8'hff : q1.size(), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
